gpu_op_arbiter: RTL and testbench



---
 rtl/gpu_op_arbiter.sv | 141 ++++++++++++++
 tb/tb_gpu_op_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_op_arbiter.sv
// Round-robin arbiter with packet lock that shares one GPU op port between NUM_REQ sources.
// Optional stall timeout is enabled by defining GPU_OP_ARBITER_TIMEOUT_EN.
module gpu_op_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int OP_WIDTH = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic [NUM_REQ*OP_WIDTH-1:0]  req_op,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [OP_WIDTH-1:0]          op,
  output logic                         op_valid,
  input  logic                         op_ready,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
  ,
  output logic                         timeout
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("gpu_op_arbiter: NUM_REQ must be 2..8 and TIMEOUT at least 1");
  end

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     scan_idx;
  logic                 found;
  logic                 owner_valid;
  logic                 xfer;
  logic [OP_WIDTH-1:0]  ops [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
    assign ops[i] = req_op[i*OP_WIDTH +: OP_WIDTH];
  end

`ifdef GPU_OP_ARBITER_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);
  logic [STALL_W-1:0] stall_q, stall_d;
`endif

  // rr_ptr doubles as the owner index while LOCKED, since it always holds the last winner.
  always_comb begin
    found    = 1'b0;
    winner   = rr_ptr_q;
    scan_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    req_ready   = '0;
    op_valid    = 1'b0;
    op          = '0;
    owner_valid = req_valid[rr_ptr_q];
    xfer        = 1'b0;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
    stall_d     = stall_q;
    timeout     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
        stall_d = '0;
`endif
        if (ce && found) begin
          state_d  = LOCKED;
          grant_d  = NUM_REQ'(1) << winner;
          rr_ptr_d = winner;
        end
      end
      LOCKED: begin
        op       = ops[rr_ptr_q];
        op_valid = ce & owner_valid;
        if (ce && op_ready) req_ready = grant_q;
        xfer = ce & owner_valid & op_ready;
        if (xfer && req_last[rr_ptr_q]) begin
          state_d = IDLE;
          grant_d = '0;
        end
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
        // A stalled owner is evicted; rr_ptr stays on it so it loses priority next round.
        if (xfer) begin
          stall_d = '0;
        end else if (ce && !owner_valid) begin
          if (stall_q == STALL_W'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            stall_d = '0;
            state_d = IDLE;
            grant_d = '0;
          end else begin
            stall_d = stall_q + STALL_W'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= PTR_W'(NUM_REQ - 1);
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      stall_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
      stall_q  <= stall_d;
`endif
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == LOCKED);

endmodule

// File: tb/tb_gpu_op_arbiter.sv
// Self-checking bench for gpu_op_arbiter: behavioural op producers plus an expected-op scoreboard.
module tb_gpu_op_arbiter;
  localparam int NUM_REQ  = 3;
  localparam int OP_WIDTH = 64;
  localparam int TIMEOUT  = 8;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        ce;
  logic [NUM_REQ*OP_WIDTH-1:0] req_op;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_last;
  logic [NUM_REQ-1:0]          req_ready;
  logic [OP_WIDTH-1:0]         op;
  logic                        op_valid;
  logic                        op_ready;
  logic [NUM_REQ-1:0]          grant;
  logic                        busy;
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
  logic                        timeout;
`endif

  int checks   = 0;
  int failures = 0;
  logic [OP_WIDTH-1:0] expQ [$];
  int pos [NUM_REQ];
  int pkt [NUM_REQ];
  int len [NUM_REQ];

  gpu_op_arbiter #(.NUM_REQ(NUM_REQ), .OP_WIDTH(OP_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .req_op    (req_op),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_ready (req_ready),
    .op        (op),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .grant     (grant),
    .busy      (busy)
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
    ,
    .timeout   (timeout)
`endif
  );

  // Free-running 10-unit clock; inputs change and outputs are sampled around the falling edge.
  always #5 clk = ~clk;

  function automatic logic [OP_WIDTH-1:0] mkOp(input int i, input int p, input int k);
    return {8'hC0, 8'(i), 24'(p), 24'(k)};
  endfunction

  task automatic doReset();
    rst       = 1'b1;
    ce        = 1'b0;
    op_ready  = 1'b0;
    req_valid = '0;
    req_last  = '0;
    req_op    = '0;
    expQ.delete();
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      pkt[i] = 0;
      len[i] = 1;
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one cycle of producer outputs at the falling edge, then let combinational outputs settle.
  task automatic tick(input logic [NUM_REQ-1:0] en, input logic ceV, input logic rdy);
    @(negedge clk);
    ce       = ceV;
    op_ready = rdy;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i] = en[i];
      req_op[i*OP_WIDTH +: OP_WIDTH] = mkOp(i, pkt[i], pos[i]);
      req_last[i] = en[i] && (pos[i] == len[i] - 1);
    end
    #1;
  endtask

  // Producers step to their next op when the handshake that will happen at the next edge is visible.
  task automatic advance();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        if (pos[i] == len[i] - 1) begin
          pos[i] = 0;
          pkt[i] = pkt[i] + 1;
        end else begin
          pos[i] = pos[i] + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    ce        = 1'b1;
    op_ready  = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_op    = '1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (grant !== 3'b000) begin failures++; $display("[TB] FAIL reset_grant: got %b required 000", grant); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b required 0", busy); end
    checks++;
    if (req_ready !== 3'b000) begin failures++; $display("[TB] FAIL reset_req_ready: got %b required 000", req_ready); end
    checks++;
    if (op_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_op_valid: got %b required 0", op_valid); end
    checks++;
    if (op !== 64'h0) begin failures++; $display("[TB] FAIL reset_op: got %h required 0", op); end
  endtask

  task automatic test_single_requester();
    logic [2:0] gE [6] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000, 3'b010};
    logic       vE [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [OP_WIDTH-1:0] e;
    doReset();
    len[1] = 3;
    for (int k = 0; k < 3; k++) expQ.push_back(mkOp(1, 0, k));
    expQ.push_back(mkOp(1, 1, 0));
    for (int c = 0; c < 6; c++) begin
      tick(3'b010, 1'b1, 1'b1);
      checks++;
      if (grant !== gE[c]) begin failures++; $display("[TB] FAIL single_grant c%0d: got %b required %b", c, grant, gE[c]); end
      checks++;
      if (op_valid !== vE[c]) begin failures++; $display("[TB] FAIL single_op_valid c%0d: got %b required %b", c, op_valid, vE[c]); end
      if (op_valid && op_ready) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL single_extra_op: got %h required none", op); end
        else begin
          e = expQ.pop_front();
          if (op !== e) begin failures++; $display("[TB] FAIL single_op c%0d: got %h required %h", c, op, e); end
        end
      end
      advance();
    end
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL single_missing_ops: got %0d left required 0", expQ.size()); end
  endtask

  task automatic test_round_robin();
    logic [2:0] gE;
    logic [OP_WIDTH-1:0] e;
    doReset();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < NUM_REQ; i++) expQ.push_back(mkOp(i, p, 0));
    for (int c = 0; c < 12; c++) begin
      tick(3'b111, 1'b1, 1'b1);
      gE = (c % 2 == 1) ? 3'(1 << ((c / 2) % 3)) : 3'b000;
      checks++;
      if (grant !== gE) begin failures++; $display("[TB] FAIL rr_grant c%0d: got %b required %b", c, grant, gE); end
      checks++;
      if (req_ready !== gE) begin failures++; $display("[TB] FAIL rr_req_ready c%0d: got %b required %b", c, req_ready, gE); end
      if (op_valid && op_ready) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL rr_extra_op: got %h required none", op); end
        else begin
          e = expQ.pop_front();
          if (op !== e) begin failures++; $display("[TB] FAIL rr_op c%0d: got %h required %h", c, op, e); end
        end
      end
      advance();
    end
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL rr_missing_ops: got %0d left required 0", expQ.size()); end
  endtask

  task automatic test_packet_lock();
    logic [2:0] gE;
    logic [2:0] rE;
    logic       bE;
    logic       rdy;
    logic [OP_WIDTH-1:0] e;
    doReset();
    len[0] = 4;
    for (int k = 0; k < 4; k++) expQ.push_back(mkOp(0, 0, k));
    expQ.push_back(mkOp(2, 0, 0));
    for (int c = 0; c < 11; c++) begin
      rdy = (c % 2 == 0);
      tick(3'b101, 1'b1, rdy);
      gE = (c >= 1 && c <= 8) ? 3'b001 : (c == 10) ? 3'b100 : 3'b000;
      bE = (gE != 3'b000);
      rE = rdy ? gE : 3'b000;
      checks++;
      if (grant !== gE) begin failures++; $display("[TB] FAIL lock_grant c%0d: got %b required %b", c, grant, gE); end
      checks++;
      if (busy !== bE) begin failures++; $display("[TB] FAIL lock_busy c%0d: got %b required %b", c, busy, bE); end
      checks++;
      if (req_ready !== rE) begin failures++; $display("[TB] FAIL lock_req_ready c%0d: got %b required %b", c, req_ready, rE); end
      if (op_valid && op_ready) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL lock_extra_op: got %h required none", op); end
        else begin
          e = expQ.pop_front();
          if (op !== e) begin failures++; $display("[TB] FAIL lock_op c%0d: got %h required %h", c, op, e); end
        end
      end
      advance();
    end
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL lock_missing_ops: got %0d left required 0", expQ.size()); end
  endtask

  task automatic test_clock_enable();
    logic [2:0] gE;
    logic [2:0] rE;
    logic       vE;
    logic       ceV;
    logic [OP_WIDTH-1:0] e;
    doReset();
    len[1] = 3;
    for (int k = 0; k < 3; k++) expQ.push_back(mkOp(1, 0, k));
    for (int c = 0; c < 10; c++) begin
      ceV = !(c >= 2 && c <= 6);
      tick(3'b010, ceV, 1'b1);
      gE = (c >= 1 && c <= 8) ? 3'b010 : 3'b000;
      vE = ceV && (gE != 3'b000);
      rE = ceV ? gE : 3'b000;
      checks++;
      if (grant !== gE) begin failures++; $display("[TB] FAIL ce_grant c%0d: got %b required %b", c, grant, gE); end
      checks++;
      if (op_valid !== vE) begin failures++; $display("[TB] FAIL ce_op_valid c%0d: got %b required %b", c, op_valid, vE); end
      checks++;
      if (req_ready !== rE) begin failures++; $display("[TB] FAIL ce_req_ready c%0d: got %b required %b", c, req_ready, rE); end
      if (op_valid && op_ready) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL ce_extra_op: got %h required none", op); end
        else begin
          e = expQ.pop_front();
          if (op !== e) begin failures++; $display("[TB] FAIL ce_op c%0d: got %h required %h", c, op, e); end
        end
      end
      advance();
    end
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL ce_missing_ops: got %0d left required 0", expQ.size()); end
  endtask

  task automatic test_reset_mid_packet();
    logic [OP_WIDTH-1:0] e;
    doReset();
    len[2] = 4;
    expQ.push_back(mkOp(2, 0, 0));
    tick(3'b100, 1'b1, 1'b1);
    advance();
    tick(3'b100, 1'b1, 1'b1);
    checks++;
    if (grant !== 3'b100) begin failures++; $display("[TB] FAIL midrst_lock: got %b required 100", grant); end
    if (op_valid && op_ready) begin
      checks++;
      e = expQ.pop_front();
      if (op !== e) begin failures++; $display("[TB] FAIL midrst_op: got %h required %h", op, e); end
    end
    advance();
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 3'b000) begin failures++; $display("[TB] FAIL midrst_grant: got %b required 000", grant); end
    checks++;
    if (op_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_op_valid: got %b required 0", op_valid); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b required 0", busy); end
    req_valid = '0;
    req_last  = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos[i] = 0;
      pkt[i] = 0;
      len[i] = 1;
    end
    expQ.delete();
    expQ.push_back(mkOp(0, 0, 0));
    tick(3'b111, 1'b1, 1'b1);
    checks++;
    if (grant !== 3'b000 || busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle: got grant %b busy %b required 000 0", grant, busy); end
    advance();
    tick(3'b111, 1'b1, 1'b1);
    checks++;
    if (grant !== 3'b001) begin failures++; $display("[TB] FAIL midrst_regrant: got %b required 001", grant); end
    if (op_valid && op_ready) begin
      checks++;
      if (expQ.size() == 0) begin failures++; $display("[TB] FAIL midrst_extra_op: got %h required none", op); end
      else begin
        e = expQ.pop_front();
        if (op !== e) begin failures++; $display("[TB] FAIL midrst_post_op: got %h required %h", op, e); end
      end
    end
    advance();
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL midrst_missing_ops: got %0d left required 0", expQ.size()); end
  endtask

`ifdef GPU_OP_ARBITER_TIMEOUT_EN
  task automatic test_timeout();
    logic [2:0] gE;
    logic       tE;
    int         pulses;
    logic [OP_WIDTH-1:0] e;
    doReset();
    len[1] = 2;
    pulses = 0;
    expQ.push_back(mkOp(2, 0, 0));
    for (int c = 0; c < 11; c++) begin
      tick((c == 0) ? 3'b110 : 3'b100, 1'b1, 1'b1);
      gE = (c >= 1 && c <= 8) ? 3'b010 : (c == 10) ? 3'b100 : 3'b000;
      tE = (c == 8);
      if (timeout === 1'b1) pulses++;
      checks++;
      if (grant !== gE) begin failures++; $display("[TB] FAIL to_grant c%0d: got %b required %b", c, grant, gE); end
      checks++;
      if (timeout !== tE) begin failures++; $display("[TB] FAIL to_pulse c%0d: got %b required %b", c, timeout, tE); end
      if (op_valid && op_ready) begin
        checks++;
        if (expQ.size() == 0) begin failures++; $display("[TB] FAIL to_extra_op: got %h required none", op); end
        else begin
          e = expQ.pop_front();
          if (op !== e) begin failures++; $display("[TB] FAIL to_op c%0d: got %h required %h", c, op, e); end
        end
      end
      advance();
    end
    checks++;
    if (pulses != 1) begin failures++; $display("[TB] FAIL to_pulse_count: got %0d required 1", pulses); end
    checks++;
    if (expQ.size() != 0) begin failures++; $display("[TB] FAIL to_missing_ops: got %0d left required 0", expQ.size()); end
  endtask
`endif

  // Scenarios run back to back; each one starts from a fresh reset.
  initial begin
    test_reset();
    test_single_requester();
    test_round_robin();
    test_packet_lock();
    test_clock_enable();
    test_reset_mid_packet();
`ifdef GPU_OP_ARBITER_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
